// File: rtl/pwm_ctrl_pkg.sv
// Shared types and defaults for the ramped PWM controller.
// Imported by the counter core and the controller top.
package pwm_ctrl_pkg;

  localparam int CW         = 16;
  localparam int DEF_PERIOD = 20;
  localparam int DEF_DUTY   = 2;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RAMP
  } state_t;

endpackage

// File: rtl/pwm_counter_core.sv
// Period counter and PWM compare for one channel.
// Settings arrive already boundary-synchronised from the controller.
module pwm_counter_core #(
  parameter int CW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic [CW-1:0] period_act,
  input  logic [CW-1:0] duty_act,
  output logic [CW-1:0] counter,
  output logic          period_end,
  output logic          pwm_out
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] cnt;
  logic          last;

  // >= keeps the wrap safe even if the period ever shrinks under the count
  assign last = (cnt >= (period_act - ONE));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!enable || last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

  assign counter    = enable ? cnt : '0;
  assign period_end = enable && last;
  assign pwm_out    = enable && !reset && (cnt < duty_act);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// PWM channel with handshaked commands, boundary-synchronised updates
// and a saturating per-period duty ramp.
module pwm_ramp_ctrl #(
  parameter int CW         = pwm_ctrl_pkg::CW,
  parameter int DEF_PERIOD = pwm_ctrl_pkg::DEF_PERIOD,
  parameter int DEF_DUTY   = pwm_ctrl_pkg::DEF_DUTY
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [CW-1:0] cmd_period,
  input  logic [CW-1:0] cmd_duty,
  input  logic [CW-1:0] cmd_step,
  output logic          pwm_out,
  output logic [CW-1:0] counter,
  output logic          period_end,
  output logic          busy,
  output logic          err
);

  import pwm_ctrl_pkg::*;

  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] P0  = CW'(DEF_PERIOD);
  localparam logic [CW-1:0] D0  = CW'(DEF_DUTY);

  state_t        state;
  logic [CW-1:0] period_act;
  logic [CW-1:0] duty_act;
  logic [CW-1:0] period_tgt;
  logic [CW-1:0] duty_tgt;
  logic [CW-1:0] step_tgt;
  logic [CW-1:0] cmd_ptgt;
  logic [CW-1:0] base;
  logic [CW-1:0] nxt_base;
  logic [CW-1:0] nxt_act;

  function automatic logic [CW-1:0] step_toward(
    input logic [CW-1:0] cur,
    input logic [CW-1:0] tgt,
    input logic [CW-1:0] stp
  );
    logic [CW:0] sum;
    sum = {1'b0, cur} + {1'b0, stp};
    if (cur <= tgt) begin
      return (sum > {1'b0, tgt}) ? tgt : sum[CW-1:0];
    end
    return ((cur - tgt) <= stp) ? tgt : (cur - stp);
  endfunction

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign cmd_ptgt  = (cmd_period == '0) ? ONE : cmd_period;
  assign base      = (duty_act < period_tgt) ? duty_act : period_tgt;
  assign nxt_base  = step_toward(base, duty_tgt, step_tgt);
  assign nxt_act   = step_toward(duty_act, duty_tgt, step_tgt);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      period_act <= P0;
      duty_act   <= D0;
      period_tgt <= P0;
      duty_tgt   <= D0;
      step_tgt   <= '0;
      err        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            period_tgt <= cmd_ptgt;
            step_tgt   <= cmd_step;
            state      <= ARMED;
            if (cmd_duty > cmd_ptgt) begin
              duty_tgt <= cmd_ptgt;
              err      <= 1'b1;
            end else begin
              duty_tgt <= cmd_duty;
            end
          end
        end
        // disabled counter already sits at 0, so loading now is glitch-free
        ARMED: begin
          if (period_end || !enable) begin
            period_act <= period_tgt;
            if (step_tgt == '0 || base == duty_tgt) begin
              duty_act <= duty_tgt;
              state    <= IDLE;
            end else begin
              duty_act <= nxt_base;
              state    <= (nxt_base == duty_tgt) ? IDLE : RAMP;
            end
          end
        end
        RAMP: begin
          if (period_end) begin
            duty_act <= nxt_act;
            if (nxt_act == duty_tgt) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  pwm_counter_core #(.CW(CW)) u_core (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .period_act (period_act),
    .duty_act   (duty_act),
    .counter    (counter),
    .period_end (period_end),
    .pwm_out    (pwm_out)
  );

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl: per-cycle expected
// waveform entries queued with stimulus, popped at negedge.
module tb_pwm_ramp_ctrl;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_period;
  logic [15:0] cmd_duty;
  logic [15:0] cmd_step;
  logic        pwm_out;
  logic [15:0] counter;
  logic        period_end;
  logic        busy;
  logic        err;

  typedef struct {
    logic [15:0] cnt;
    logic        pwm;
    logic        pe;
    logic        bsy;
    logic        er;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  pwm_ramp_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_period (cmd_period),
    .cmd_duty   (cmd_duty),
    .cmd_step   (cmd_step),
    .pwm_out    (pwm_out),
    .counter    (counter),
    .period_end (period_end),
    .busy       (busy),
    .err        (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_raw(input int c, input bit p, input bit e,
                          input bit b, input bit r);
    exp_t x;
    x.cnt = 16'(c);
    x.pwm = p;
    x.pe  = e;
    x.bsy = b;
    x.er  = r;
    sb.push_back(x);
  endtask

  task automatic push_period(input int per, input int duty,
                             input int from, input int to,
                             input bit b, input bit r);
    for (int i = from; i <= to; i++) begin
      push_raw(i, i < duty, i == per - 1, b, r);
    end
  endtask

  task automatic drain();
    exp_t x;
    while (sb.size() > 0) begin
      @(negedge clock);
      x = sb.pop_front();
      chk("counter", 32'(counter), 32'(x.cnt));
      chk("pwm_out", 32'(pwm_out), 32'(x.pwm));
      chk("period_end", 32'(period_end), 32'(x.pe));
      chk("busy", 32'(busy), 32'(x.bsy));
      chk("cmd_ready", 32'(cmd_ready), 32'(!x.bsy));
      chk("err", 32'(err), 32'(x.er));
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    enable    = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clock);
    chk("rst_counter", 32'(counter), 32'd0);
    chk("rst_pwm", 32'(pwm_out), 32'd0);
    chk("rst_pe", 32'(period_end), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    @(posedge clock);
    #1;
    reset  = 1'b0;
    enable = 1'b1;
  endtask

  task automatic send_cmd(input int p, input int d, input int s);
    cmd_period = 16'(p);
    cmd_duty   = 16'(d);
    cmd_step   = 16'(s);
    cmd_valid  = 1'b1;
    chk("ready_pre", 32'(cmd_ready), 32'd1);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    cmd_valid  = 1'b0;
    cmd_period = '0;
    cmd_duty   = '0;
    cmd_step   = '0;

    // defaults 20/2
    do_reset();
    push_period(20, 2, 0, 19, 0, 0);
    drain();

    // jump to 10/5 issued mid-period
    push_period(20, 2, 0, 7, 0, 0);
    drain();
    send_cmd(10, 5, 0);
    push_period(20, 2, 8, 19, 1, 0);
    push_period(10, 5, 0, 9, 0, 0);
    drain();

    // ramp up 2 -> 8 step 3, then down to 1
    do_reset();
    push_period(20, 2, 0, 0, 0, 0);
    drain();
    send_cmd(20, 8, 3);
    push_period(20, 2, 1, 19, 1, 0);
    push_period(20, 5, 0, 19, 1, 0);
    push_period(20, 8, 0, 19, 0, 0);
    drain();
    send_cmd(20, 1, 3);
    push_period(20, 8, 0, 19, 1, 0);
    push_period(20, 5, 0, 19, 1, 0);
    push_period(20, 2, 0, 19, 1, 0);
    push_period(20, 1, 0, 19, 0, 0);
    drain();

    // duty clamped to period, err sticky
    send_cmd(10, 15, 0);
    push_period(20, 1, 0, 19, 1, 1);
    push_period(10, 10, 0, 9, 0, 1);
    drain();
    send_cmd(10, 3, 0);
    push_period(10, 10, 0, 9, 1, 1);
    push_period(10, 3, 0, 9, 0, 1);
    drain();

    // disable with a pending command
    send_cmd(20, 6, 0);
    enable = 1'b0;
    push_raw(0, 0, 0, 1, 1);
    push_raw(0, 0, 0, 0, 1);
    push_raw(0, 0, 0, 0, 1);
    drain();
    @(posedge clock);
    #1;
    enable = 1'b1;
    push_period(20, 6, 0, 19, 0, 1);
    drain();

    // async reset mid-ramp
    do_reset();
    push_period(20, 2, 0, 0, 0, 0);
    drain();
    send_cmd(20, 8, 3);
    push_period(20, 2, 1, 19, 1, 0);
    push_period(20, 5, 0, 9, 1, 0);
    drain();
    reset = 1'b1;
    #1;
    chk("arst_counter", 32'(counter), 32'd0);
    chk("arst_pwm", 32'(pwm_out), 32'd0);
    chk("arst_pe", 32'(period_end), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(cmd_ready), 32'd1);
    do_reset();
    push_period(20, 2, 0, 19, 0, 0);
    push_period(20, 2, 0, 19, 0, 0);
    drain();

    // period 0 -> 1 with duty 0, then duty == period
    send_cmd(0, 0, 0);
    push_period(20, 2, 0, 19, 1, 0);
    for (int k = 0; k < 4; k++) push_period(1, 0, 0, 0, 0, 0);
    drain();
    send_cmd(1, 1, 0);
    push_period(1, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) push_period(1, 1, 0, 0, 0, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
Controller plus generator for a single PWM channel.
- Accepts period/duty/ramp-step commands over a valid/ready handshake.
- Applies new settings only at period boundaries (glitch-free).
- Ramps duty toward the target by a programmable step once per period.
- Sits between the register/command interface and the motor/LED drive pin. Replaces free-running fixed-duty PWM with scheduled, boundary-synchronised updates.

Parameters:
CW, 16, width of counter, period, duty and step.
DEF_PERIOD, 20, period_act after reset (cycles).
DEF_DUTY, 2, duty_act after reset (high cycles per period).

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
enable  in  1  1 = run counter/PWM; 0 = counter held at 0, pwm_out low
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_period  in  CW  requested period in cycles
cmd_duty  in  CW  requested high cycles per period
cmd_step  in  CW  duty change per period; 0 = jump directly
pwm_out  out  1  PWM output
counter  out  CW  current position in period, 0..period_act-1
period_end  out  1  1-cycle pulse on the last cycle of a period
busy  out  1  command pending or ramp in progress
err  out  1  sticky: a command's duty exceeded its period and was clamped

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clock. All state is updated on the rising edge of clock.
- Reset values:
  - counter=0, pwm_out=0, period_end=0, busy=0, err=0, cmd_ready=1.
  - period_act=DEF_PERIOD, duty_act=DEF_DUTY, state=IDLE.
  - Reset mid-ramp abandons the command entirely.
- Counter (enable=1):
  - Increments each cycle; when counter==period_act-1 it wraps to 0 next cycle.
  - period_end=1 exactly in the cycle counter==period_act-1.
  - period_act=1: counter stays 0 and period_end is high every cycle.
- PWM invariant: every cycle, pwm_out == enable && (counter < duty_act).
  - duty_act=0 gives constant low.
  - duty_act=period_act gives constant high.
- enable=0: counter forced to 0, pwm_out=0, period_end=0. Command state is retained; ramp steps freeze.
- Command accept:
  - A command is taken in the cycle cmd_valid && cmd_ready.
  - Latches period_tgt = max(cmd_period,1), duty_tgt and step_tgt.
  - If cmd_duty > period_tgt: duty_tgt=period_tgt and err set to 1 (sticky until reset).
- FSM: IDLE, ARMED, RAMP.
  - cmd_ready = (state==IDLE). busy = (state!=IDLE).
- IDLE: on accept -> ARMED.
- ARMED: load on the first period_end, or on the next cycle if enable=0 (counter already at 0). The load does the following:
  - period_act <= period_tgt.
  - Base duty = min(duty_act, period_tgt).
  - If step_tgt==0 or base==duty_tgt: duty_act <= duty_tgt, -> IDLE.
  - Otherwise duty_act <= base stepped once toward duty_tgt, -> RAMP; or -> IDLE if that step reaches the target.
- RAMP: on each period_end, step duty_act toward duty_tgt; -> IDLE in the same cycle duty_act becomes duty_tgt.
- Step arithmetic is saturating and never overshoots:
  - Up: min(duty_act+step, duty_tgt), computed in CW+1 bits.
  - Down: if (duty_act-duty_tgt) <= step then duty_tgt else duty_act-step.
- Update timing: new period_act/duty_act are visible from the cycle after period_end, i.e. counter==0 of the new period. A partial period never mixes old and new settings.
- cmd_valid while busy is ignored; the sender holds it until cmd_ready.

Decomposition:
- Package pwm_ctrl_pkg: state enum (IDLE, ARMED, RAMP), CW, DEF_PERIOD, DEF_DUTY.
- Sub-module pwm_counter_core: counter, wrap, period_end, and the pwm_out compare against period_act/duty_act inputs.
- The controller FSM and shadow/target registers stay in pwm_ramp_ctrl.

Test Plan:
- Reset, enable=1, defaults -> pwm_out high at counter 0,1, low at 2..19; period_end every 20 cycles; busy=0, err=0.
- Command period=10, duty=5, step=0 issued at counter=7 -> old 20/2 waveform completes to counter 19; then counter 0..9 with pwm high 0..4; cmd_ready low until that load cycle.
- Command period=20, duty=8, step=3 from duty 2 -> duty_act 5 after 1st period_end, 8 after 2nd; busy drops with the 2nd; then duty 8→1 step 3 gives 5, 2, 1.
- Command period=10, duty=15 -> duty_act=10, pwm_out constant high, err=1 and stays 1 across later valid commands.
- enable=0 with command pending -> load the next cycle, counter=0, pwm_out=0; re-enable -> new waveform from counter 0.
- Reset asserted mid-RAMP (duty 5 of target 8) -> immediate async return to 20/2 defaults, cmd_ready=1, busy=0, no further steps.
